// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates load-use, branch, mult/div and
// data-memory wait conditions into per-register write/flush/bubble controls.
module pipeline_stall_controller #(
    parameter int unsigned MULDIV_CYCLES = 32,
    parameter int unsigned CNT_W         = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hdu_out,
    input  logic        branch_taken,
    input  logic        ex_muldiv_start,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_write,
    output logic        idex_bubble,
    output logic        exmem_write,
    output logic        exmem_bubble,
    output logic        memwb_bubble,
    output logic        muldiv_busy,
    output logic [1:0]  ctrl_state,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMuldiv  = 2'd1,
        StMemwait = 2'd2,
        StIllegal = 2'd3
    } state_e;

    // The start cycle counts as the first mult/div cycle, so MULDIV holds one fewer.
    localparam logic [CNT_W-1:0] CntInit = CNT_W'(MULDIV_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_count_q, stall_count_d;
    logic             mem_stall;

    assign mem_stall = dmem_req && !dmem_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StRun;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StRun: begin
                if (mem_stall) begin
                    state_d = StMemwait;
                end else if (ex_muldiv_start) begin
                    state_d = StMuldiv;
                    cnt_d   = CntInit;
                end
            end
            StMuldiv: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = mem_stall ? StMemwait : StRun;
                end
            end
            StMemwait: begin
                if (dmem_ready) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // Output logic; outputs are forced to defaults while reset is held so that an aborted
    // mult/div or memory wait leaves no residual stall.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        exmem_bubble = 1'b0;
        memwb_bubble = 1'b0;
        muldiv_busy  = 1'b0;
        if (!reset) begin
            case (state_q)
                StRun: begin
                    if (mem_stall) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_write  = 1'b0;
                        memwb_bubble = 1'b1;
                    end else if (ex_muldiv_start) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_bubble = 1'b1;
                    end else if (branch_taken) begin
                        ifid_flush   = 1'b1;
                        idex_bubble  = 1'b1;
                    end else if (hdu_out) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_bubble  = 1'b1;
                    end
                end
                StMuldiv: begin
                    muldiv_busy  = 1'b1;
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_bubble = 1'b1;
                    if (mem_stall) begin
                        exmem_write  = 1'b0;
                        memwb_bubble = 1'b1;
                    end
                end
                StMemwait: begin
                    if (!dmem_ready) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_write  = 1'b0;
                        memwb_bubble = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall_count_d = pc_write ? stall_count_q : stall_count_q + 32'd1;
    assign stall_count   = stall_count_q;
    assign ctrl_state    = state_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with MULDIV_CYCLES=4; outputs are packed into a
// 9-bit vector {pc_w, ifid_w, ifid_flush, idex_w, idex_bub, exmem_w, exmem_bub, memwb_bub, busy}.
module tb_pipeline_stall_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        hdu_out, branch_taken, ex_muldiv_start, dmem_req, dmem_ready;
    logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
    logic        exmem_write, exmem_bubble, memwb_bubble, muldiv_busy;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    localparam logic [8:0] OutDef    = 9'b1_1_0_1_0_1_0_0_0;
    localparam logic [8:0] OutHdu    = 9'b0_0_0_1_1_1_0_0_0;
    localparam logic [8:0] OutBranch = 9'b1_1_1_1_1_1_0_0_0;
    localparam logic [8:0] OutStart  = 9'b0_0_0_0_0_1_1_0_0;
    localparam logic [8:0] OutMd     = 9'b0_0_0_0_0_1_1_0_1;
    localparam logic [8:0] OutMdMem  = 9'b0_0_0_0_0_0_1_1_1;
    localparam logic [8:0] OutFreeze = 9'b0_0_0_0_0_0_0_1_0;

    logic [8:0] outs;
    assign outs = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                   exmem_write, exmem_bubble, memwb_bubble, muldiv_busy};

    pipeline_stall_controller #(
        .MULDIV_CYCLES(4),
        .CNT_W        (6)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .hdu_out        (hdu_out),
        .branch_taken   (branch_taken),
        .ex_muldiv_start(ex_muldiv_start),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_write     (idex_write),
        .idex_bubble    (idex_bubble),
        .exmem_write    (exmem_write),
        .exmem_bubble   (exmem_bubble),
        .memwb_bubble   (memwb_bubble),
        .muldiv_busy    (muldiv_busy),
        .ctrl_state     (ctrl_state),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock, land 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hdu_out = 1'b0; branch_taken = 1'b0; ex_muldiv_start = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        #1;
        check("reset_outs", 32'(outs), 32'(OutDef));
        check("reset_state", 32'(ctrl_state), 32'd0);
        check("reset_count", stall_count, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_outs", 32'(outs), 32'(OutDef));
            check("idle_state", 32'(ctrl_state), 32'd0);
            check("idle_count", stall_count, 32'd0);
        end

        // Load-use bubble.
        hdu_out = 1'b1;
        #1 check("hdu_outs", 32'(outs), 32'(OutHdu));
        step();
        hdu_out = 1'b0;
        #1 check("hdu_after_outs", 32'(outs), 32'(OutDef));
        check("hdu_count", stall_count, 32'd1);

        // Branch beats load-use.
        branch_taken = 1'b1; hdu_out = 1'b1;
        #1 check("br_hdu_outs", 32'(outs), 32'(OutBranch));
        step();
        clear_inputs();
        #1 check("br_count", stall_count, 32'd1);
        check("br_after_outs", 32'(outs), 32'(OutDef));

        // Mult/div: 4 stalled cycles, 3 in MULDIV.
        ex_muldiv_start = 1'b1;
        #1 check("md_start_outs", 32'(outs), 32'(OutStart));
        check("md_start_state", 32'(ctrl_state), 32'd0);
        step();
        ex_muldiv_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("md_state", 32'(ctrl_state), 32'd1);
            check("md_outs", 32'(outs), 32'(OutMd));
            step();
        end
        #1 check("md_end_state", 32'(ctrl_state), 32'd0);
        check("md_end_outs", 32'(outs), 32'(OutDef));
        check("md_count", stall_count, 32'd5);

        // Memory wait: 3 freeze cycles, release on the 4th.
        dmem_req = 1'b1; dmem_ready = 1'b0;
        #1 check("mw_first_outs", 32'(outs), 32'(OutFreeze));
        check("mw_first_state", 32'(ctrl_state), 32'd0);
        step();
        for (int i = 0; i < 2; i++) begin
            check("mw_state", 32'(ctrl_state), 32'd2);
            check("mw_outs", 32'(outs), 32'(OutFreeze));
            step();
        end
        dmem_ready = 1'b1;
        #1 check("mw_rel_state", 32'(ctrl_state), 32'd2);
        check("mw_rel_outs", 32'(outs), 32'(OutDef));
        step();
        #1 check("mw_end_state", 32'(ctrl_state), 32'd0);
        check("mw_count", stall_count, 32'd8);

        // Ready in the request cycle: no stall.
        #1 check("mw_fast_outs", 32'(outs), 32'(OutDef));
        step();
        clear_inputs();
        #1 check("mw_fast_state", 32'(ctrl_state), 32'd0);
        check("mw_fast_count", stall_count, 32'd8);

        // Mult/div ending while memory waits goes to MEMWAIT.
        ex_muldiv_start = 1'b1;
        step();
        ex_muldiv_start = 1'b0;
        step();
        step();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        #1 check("mdmem_outs", 32'(outs), 32'(OutMdMem));
        check("mdmem_state", 32'(ctrl_state), 32'd1);
        step();
        check("mdmem_next_state", 32'(ctrl_state), 32'd2);
        dmem_ready = 1'b1;
        #1 check("mdmem_rel_outs", 32'(outs), 32'(OutDef));
        step();
        clear_inputs();
        #1 check("mdmem_end_state", 32'(ctrl_state), 32'd0);
        check("mdmem_count", stall_count, 32'd12);

        // Reset on the 2nd MULDIV cycle aborts the sequence.
        ex_muldiv_start = 1'b1;
        step();
        ex_muldiv_start = 1'b0;
        step();
        reset = 1'b1;
        #1 check("rst_md_state_before", 32'(ctrl_state), 32'd1);
        check("rst_md_outs_during", 32'(outs), 32'(OutDef));
        step();
        reset = 1'b0;
        #1 check("rst_md_state", 32'(ctrl_state), 32'd0);
        check("rst_md_outs", 32'(outs), 32'(OutDef));
        check("rst_md_count", stall_count, 32'd0);
        step();
        check("rst_md_state_hold", 32'(ctrl_state), 32'd0);
        check("rst_md_count_hold", stall_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
